// File: rtl/raxi_rq_arb_pkg.sv
// Shared definitions for the RQ write-side arbiter and the RQ FIFO wrapper.
// Holds the FSM encoding and the default bit positions inside a FIFO-format beat.
package raxi_rq_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    localparam int DEF_DATA_WTH = 288;
    localparam int DEF_EOP_POS  = 262;
    localparam int DEF_ERR_POS  = 261;

endpackage

// File: rtl/raxi_rq_arb_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', ascending with wrap.
// Kept generic so the CQ/CC paths can reuse it.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    always_comb begin
        logic found;
        found   = 1'b0;
        gnt     = '0;
        gnt_idx = '0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (int'(last) + k) % N;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx[IW-1:0];
            end
        end
        any = |req;
    end

endmodule

// File: rtl/raxi_rq_arb.sv
// Packet-level round-robin arbiter for the write side of the PCIe RQ transmit FIFO.
// Grant is held from first beat to EOP; also keeps per-port packet counters.
module raxi_rq_arb
    import raxi_rq_arb_pkg::*;
#(
    parameter int         REQ_NUM   = 4,
    parameter int         DATA_WTH  = DEF_DATA_WTH,
    parameter int         EOP_POS   = DEF_EOP_POS,
    parameter int         ERR_POS   = DEF_ERR_POS,
    parameter logic [8:0] MAX_BEATS = 9'd32
) (
    input  logic                         user_clk,
    input  logic                         user_rst,
    input  logic [REQ_NUM-1:0]           req_vld,
    input  logic [REQ_NUM*DATA_WTH-1:0]  req_data,
    output logic [REQ_NUM-1:0]           req_rdy,
    input  logic [REQ_NUM-1:0]           reg_arb_en,
    output logic                         rq_tx_wr,
    output logic [DATA_WTH-1:0]          rq_tx_wdata,
    input  logic                         rq_tx_ff,
    output logic [REQ_NUM-1:0]           arb_gnt,
    output logic                         arb_len_err,
    output logic [REQ_NUM*16-1:0]        pkt_cnt
);

    localparam int IW = $clog2(REQ_NUM);

    arb_state_t            state_reg;
    logic [REQ_NUM-1:0]    arb_gnt_reg;
    logic [IW-1:0]         gnt_idx_reg;
    logic [IW-1:0]         last_gnt_reg;
    logic [8:0]            beat_cnt_reg;
    logic                  wr_reg;
    logic [DATA_WTH-1:0]   wdata_reg;
    logic                  len_err_reg;
    logic [REQ_NUM*16-1:0] pkt_cnt_reg;
    logic [REQ_NUM*16-1:0] pkt_cnt_next;

    logic [DATA_WTH-1:0]   beat_arr [REQ_NUM];
    logic [REQ_NUM-1:0]    cand;
    logic [REQ_NUM-1:0]    pick_gnt;
    logic [IW-1:0]         pick_idx;
    logic                  pick_any;
    logic                  accept;
    logic [DATA_WTH-1:0]   cur_beat;
    logic [DATA_WTH-1:0]   out_beat;
    logic [8:0]            beat_cnt_inc;
    logic                  beat_eop;
    logic                  len_hit;
    logic                  eop_done;

    genvar gi;
    generate
        for (gi = 0; gi < REQ_NUM; gi++) begin : g_port
            assign beat_arr[gi] = req_data[gi*DATA_WTH +: DATA_WTH];
            assign pkt_cnt_next[gi*16 +: 16] = (eop_done && gnt_idx_reg == IW'(gi))
                                             ? pkt_cnt_reg[gi*16 +: 16] + 16'd1
                                             : pkt_cnt_reg[gi*16 +: 16];
        end
    endgenerate

    // Almost-full blocks new grants as well as beats of the packet in flight.
    assign cand = req_vld & reg_arb_en & {REQ_NUM{~rq_tx_ff}};

    rr_pick #(
        .N  (REQ_NUM),
        .IW (IW)
    ) u_pick (
        .req     (cand),
        .last    (last_gnt_reg),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign req_rdy      = (state_reg == ST_BUSY) ? (arb_gnt_reg & req_vld & {REQ_NUM{~rq_tx_ff}}) : '0;
    assign accept       = |req_rdy;
    assign cur_beat     = beat_arr[gnt_idx_reg];
    assign beat_cnt_inc = beat_cnt_reg + 9'd1;
    assign beat_eop     = cur_beat[EOP_POS];
    assign len_hit      = !beat_eop && (beat_cnt_inc == MAX_BEATS);
    assign eop_done     = accept && beat_eop;

    // An over-long packet is closed with EOP+ERR so the FIFO drops it.
    always_comb begin
        out_beat = cur_beat;
        if (len_hit) begin
            out_beat[EOP_POS] = 1'b1;
            out_beat[ERR_POS] = 1'b1;
        end
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state_reg    <= ST_IDLE;
            arb_gnt_reg  <= '0;
            gnt_idx_reg  <= '0;
            last_gnt_reg <= IW'(REQ_NUM - 1);
            beat_cnt_reg <= '0;
            wr_reg       <= 1'b0;
            wdata_reg    <= '0;
            len_err_reg  <= 1'b0;
            pkt_cnt_reg  <= '0;
        end else begin
            wr_reg      <= accept;
            pkt_cnt_reg <= pkt_cnt_next;
            if (accept) begin
                wdata_reg <= out_beat;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (pick_any) begin
                        arb_gnt_reg <= pick_gnt;
                        gnt_idx_reg <= pick_idx;
                        state_reg   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (accept) begin
                        if (beat_eop) begin
                            last_gnt_reg <= gnt_idx_reg;
                            beat_cnt_reg <= '0;
                            arb_gnt_reg  <= '0;
                            state_reg    <= ST_IDLE;
                        end else if (len_hit) begin
                            len_err_reg  <= 1'b1;
                            beat_cnt_reg <= '0;
                            arb_gnt_reg  <= '0;
                            state_reg    <= ST_IDLE;
                        end else begin
                            beat_cnt_reg <= beat_cnt_inc;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign rq_tx_wr    = wr_reg;
    assign rq_tx_wdata = wdata_reg;
    assign arb_gnt     = arb_gnt_reg;
    assign arb_len_err = len_err_reg;
    assign pkt_cnt     = pkt_cnt_reg;

endmodule

// File: tb/tb_raxi_rq_arb.sv
// Randomized self-checking bench for raxi_rq_arb against a packet-level reference model.
// Each port holds a beat stream; the model derives the expected FIFO write stream from it.
module tb_raxi_rq_arb;

    localparam int N     = 4;
    localparam int W     = 288;
    localparam int EOP   = 262;
    localparam int ERR   = 261;
    localparam int MAXB  = 32;
    localparam int DEPTH = 1024;

    typedef logic [W-1:0] beat_t;

    logic             user_clk = 1'b0;
    logic             user_rst = 1'b1;
    logic [N-1:0]     req_vld = '0;
    logic [N*W-1:0]   req_data = '0;
    logic [N-1:0]     req_rdy;
    logic [N-1:0]     reg_arb_en = '1;
    logic             rq_tx_wr;
    logic [W-1:0]     rq_tx_wdata;
    logic             rq_tx_ff = 1'b0;
    logic [N-1:0]     arb_gnt;
    logic             arb_len_err;
    logic [N*16-1:0]  pkt_cnt;

    raxi_rq_arb #(
        .REQ_NUM   (N),
        .DATA_WTH  (W),
        .EOP_POS   (EOP),
        .ERR_POS   (ERR),
        .MAX_BEATS (9'd32)
    ) dut (
        .user_clk    (user_clk),
        .user_rst    (user_rst),
        .req_vld     (req_vld),
        .req_data    (req_data),
        .req_rdy     (req_rdy),
        .reg_arb_en  (reg_arb_en),
        .rq_tx_wr    (rq_tx_wr),
        .rq_tx_wdata (rq_tx_wdata),
        .rq_tx_ff    (rq_tx_ff),
        .arb_gnt     (arb_gnt),
        .arb_len_err (arb_len_err),
        .pkt_cnt     (pkt_cnt)
    );

    always #5 user_clk = ~user_clk;

    int checks = 0;
    int errors = 0;

    // Per-port beat streams and the expected FIFO write stream
    beat_t       pbuf [N][DEPTH];
    int          phead [N];
    int          ptail [N];
    beat_t       exp_q [$];
    logic [15:0] exp_pkt [N];
    logic        exp_len_err;
    int          model_last;
    logic [N-1:0] seen_gnt;
    logic [N*16-1:0] force_val;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic add_pkt(input int p, input int len, input bit eop_last);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            for (int k = 0; k < W / 32; k++) b[k*32 +: 32] = $urandom;
            b[EOP] = eop_last && (i == len - 1);
            pbuf[p][ptail[p]] = b;
            ptail[p]++;
        end
    endtask

    task automatic drive_ports();
        for (int p = 0; p < N; p++) begin
            req_vld[p] = phead[p] < ptail[p];
            req_data[p*W +: W] = (phead[p] < ptail[p]) ? pbuf[p][phead[p]] : '0;
        end
    endtask

    // Reference: round-robin over enabled ports with pending beats; a packet ends
    // at EOP, or after MAXB beats where it is closed with EOP+ERR.
    task automatic build_expected();
        int cur [N];
        int p;
        int cnt;
        bit found;
        bit seg_end;
        beat_t b;
        for (int q = 0; q < N; q++) cur[q] = phead[q];
        while (1) begin
            found = 0;
            p = 0;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (model_last + k) % N;
                if (!found && reg_arb_en[c] && cur[c] < ptail[c]) begin
                    found = 1;
                    p = c;
                end
            end
            if (!found) break;
            cnt = 0;
            seg_end = 0;
            while (!seg_end && cur[p] < ptail[p]) begin
                b = pbuf[p][cur[p]];
                cur[p]++;
                cnt++;
                if (b[EOP]) begin
                    exp_pkt[p]++;
                    model_last = p;
                    seg_end = 1;
                end else if (cnt == MAXB) begin
                    b[EOP] = 1'b1;
                    b[ERR] = 1'b1;
                    exp_len_err = 1'b1;
                    seg_end = 1;
                end
                exp_q.push_back(b);
            end
        end
    endtask

    // ff_mode: 0 never full, 1 random almost-full, 2 five-cycle stall after two port-2 beats
    task automatic run(input int max_cyc, input int ff_mode, input bit clr_en3, input logic [N-1:0] first_gnt);
        logic [N-1:0] rdy_prev;
        int eop_age;
        int ff_left;
        int acc2;
        bit ff_done;
        bit done;
        beat_t exp_b;
        build_expected();
        eop_age = 0; ff_left = 0; acc2 = 0; ff_done = 0; done = 0;
        seen_gnt = '0;
        rq_tx_ff = 1'b0;
        drive_ports();
        #1;
        rdy_prev = req_rdy;
        for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
            @(posedge user_clk);
            #1;
            for (int p = 0; p < N; p++) begin
                if (rdy_prev[p]) begin
                    phead[p]++;
                    if (p == 2) acc2++;
                end
            end
            if (cyc == 0 && first_gnt != '0) chk("first_gnt", arb_gnt, first_gnt);
            chk("gnt_onehot", $onehot0(arb_gnt), 1);
            seen_gnt = seen_gnt | arb_gnt;
            if (ff_mode == 0 && eop_age == 1) begin
                chk("gap_idle", rq_tx_wr, 0);
                eop_age = 2;
            end else if (ff_mode == 0 && eop_age == 2) begin
                if (exp_q.size() != 0) chk("gap_next", rq_tx_wr, 1);
                eop_age = 0;
            end
            if (rq_tx_wr) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    exp_b = exp_q.pop_front();
                    chk("beat", rq_tx_wdata, exp_b);
                end
                if (rq_tx_wdata[EOP]) begin
                    eop_age = 1;
                    $display("tx packet end at %0t, %0d beats left", $time, exp_q.size());
                end
                if (clr_en3) reg_arb_en[3] = 1'b0;
            end
            if (exp_q.size() == 0) done = 1;
            case (ff_mode)
                1: rq_tx_ff = ($urandom_range(0, 3) == 0);
                2: begin
                    if (!ff_done && acc2 >= 2) begin
                        ff_left = 5;
                        ff_done = 1;
                    end
                    rq_tx_ff = (ff_left > 0);
                    if (ff_left > 0) ff_left--;
                end
                default: rq_tx_ff = 1'b0;
            endcase
            drive_ports();
            #1;
            if (rq_tx_ff) chk("rdy_ff", req_rdy, 0);
            chk("rdy_valid", $onehot0(req_rdy) && ((req_rdy & ~req_vld) == '0), 1);
            rdy_prev = req_rdy;
        end
        if (!done) begin
            chk("timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        chk("quiet", rdy_prev, 0);
        chk("len_err", arb_len_err, exp_len_err);
        for (int p = 0; p < N; p++) chk("pkt_cnt", pkt_cnt[p*16 +: 16], exp_pkt[p]);
    endtask

    task automatic model_reset();
        for (int p = 0; p < N; p++) begin
            phead[p] = 0;
            ptail[p] = 0;
            exp_pkt[p] = '0;
        end
        exp_q.delete();
        exp_len_err = 1'b0;
        model_last = N - 1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge user_clk);
        #1;
        chk("rst_wr", rq_tx_wr, 0);
        chk("rst_wdata", rq_tx_wdata, 0);
        chk("rst_gnt", arb_gnt, 0);
        chk("rst_rdy", req_rdy, 0);
        chk("rst_len_err", arb_len_err, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        @(negedge user_clk);
        user_rst = 1'b0;

        // Single 3-beat packet on port 0
        add_pkt(0, 3, 1);
        run(100, 0, 0, 4'b0001);

        // All ports offering back-to-back 2-beat packets
        for (int p = 0; p < N; p++) begin
            add_pkt(p, 2, 1);
            add_pkt(p, 2, 1);
        end
        run(200, 0, 0, '0);

        // Almost-full stall in the middle of a port-2 packet
        add_pkt(2, 6, 1);
        add_pkt(0, 2, 1);
        run(200, 2, 0, '0);

        // Masked port 1 must never win; port 3 loses its enable mid-packet
        reg_arb_en = 4'b1101;
        add_pkt(1, 3, 1);
        add_pkt(3, 4, 1);
        run(200, 0, 1, '0);
        chk("masked_port1", seen_gnt[1], 0);
        reg_arb_en = 4'b1111;
        run(100, 0, 0, '0);

        // Random traffic with random almost-full
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < N; p++) begin
                int np;
                np = $urandom_range(0, 4);
                for (int k = 0; k < np; k++) add_pkt(p, $urandom_range(1, 5), 1);
            end
            run(2000, (r % 2 == 0) ? 1 : 0, 0, '0);
        end

        // 40-beat packet: first 32 beats cut off with EOP+ERR, rest is a new packet
        add_pkt(1, 40, 1);
        run(300, 0, 0, '0);

        // Counter wrap on port 0
        @(negedge user_clk);
        force_val = {pkt_cnt[N*16-1:16], 16'hFFFF};
        force dut.pkt_cnt_reg = force_val;
        @(posedge user_clk);
        #1;
        release dut.pkt_cnt_reg;
        exp_pkt[0] = 16'hFFFF;
        add_pkt(0, 2, 1);
        run(100, 0, 0, '0);

        // Reset in the middle of a port-2 packet
        add_pkt(2, 5, 1);
        drive_ports();
        rq_tx_ff = 1'b0;
        repeat (3) @(posedge user_clk);
        @(negedge user_clk);
        user_rst = 1'b1;
        #1;
        chk("mid_rst_wr", rq_tx_wr, 0);
        chk("mid_rst_wdata", rq_tx_wdata, 0);
        chk("mid_rst_gnt", arb_gnt, 0);
        chk("mid_rst_rdy", req_rdy, 0);
        chk("mid_rst_len_err", arb_len_err, 0);
        chk("mid_rst_pkt_cnt", pkt_cnt, 0);
        model_reset();
        drive_ports();
        @(negedge user_clk);
        user_rst = 1'b0;

        // After reset port 0 wins ahead of port 3
        add_pkt(3, 2, 1);
        add_pkt(0, 3, 1);
        run(100, 0, 0, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/raxi_rq_arb.md
# raxi_rq_arb

Packet-level round-robin arbiter sharing the write side of the 256-bit PCIe RQ transmit FIFO among up to four user-side requesters (DMA read engine, DMA write engine, BD fetch, message path). It sits in the user clock domain, directly ahead of the `rq_tx_wr`/`rq_tx_wdata`/`rq_tx_ff` port of the RQ FIFO. Grant is held for a whole TLP, ending at the EOP beat, so beats from different requesters never interleave. It also keeps per-port packet statistics.

## Interface
- `REQ_NUM`, 4: number of requesters, 2..4.
- `DATA_WTH`, 288: beat width, already in FIFO format (byte-enables, EOP, ERR, parity field).
- `EOP_POS`, 262: bit index of end-of-packet in a beat.
- `MAX_BEATS`, 9'd32: longest legal packet, in beats.

- `user_clk`  in  1: user clock; the only clock.
- `user_rst`  in  1: asynchronous, active-high reset.
- `req_vld`  in  REQ_NUM: beat valid, one bit per requester.
- `req_data`  in  REQ_NUM*DATA_WTH: beats; port i uses bits [i*DATA_WTH +: DATA_WTH].
- `req_rdy`  out  REQ_NUM: beat accepted. Combinational.
- `reg_arb_en`  in  REQ_NUM: per-port arbitration enable.
- `rq_tx_wr`  out  1: FIFO write strobe. Registered.
- `rq_tx_wdata`  out  DATA_WTH: FIFO write data. Registered.
- `rq_tx_ff`  in  1: FIFO almost-full.
- `arb_gnt`  out  REQ_NUM: one-hot current grant. Registered.
- `arb_len_err`  out  1: sticky; set when a packet exceeds `MAX_BEATS`.
- `pkt_cnt`  out  REQ_NUM*16: per-port count of completed packets.

## Operation
- FSM has two states: IDLE and BUSY.
- IDLE:
  - Candidates are ports with `req_vld & reg_arb_en`, and only while `rq_tx_ff`=0.
  - Pick the first candidate after `last_gnt`, in ascending order with wrap.
  - Register the pick into `arb_gnt`, then go to BUSY.
  - `req_rdy` is 0 in IDLE.
  - `last_gnt` resets to port REQ_NUM-1, so port 0 wins first.
- BUSY with grant g:
  - `req_rdy[g] = req_vld[g] & ~rq_tx_ff`. All other `req_rdy` bits are 0.
  - An accepted beat is registered to `rq_tx_wdata`, with `rq_tx_wr`=1 on the next cycle.
  - `beat_cnt` (9 bits) increments on each accepted beat.
  - On an accepted beat with bit `EOP_POS` set:
    - `pkt_cnt[g]` increments, wrapping at 16'hFFFF to 0.
    - `last_gnt` = g, `beat_cnt` = 0.
    - Go to IDLE; `arb_gnt` = 0 on the next cycle.
- Length guard: if an accepted beat makes `beat_cnt` equal `MAX_BEATS` and that beat has no EOP:
  - The beat is forwarded with bit `EOP_POS` forced to 1 and bit `ERR_POS` (261) forced to 1. The FIFO's error-drop then discards the packet.
  - `arb_len_err` is set and the FSM returns to IDLE.
  - Any remaining beats of that packet are arbitrated later as a new packet.
  - `arb_len_err` is cleared only by reset.
- Clearing `reg_arb_en[g]` in BUSY does not abort: the packet in flight completes. The mask applies only in IDLE.
- `req_vld[g]` dropping mid-packet causes a stall; grant is held indefinitely.
- Reset mid-packet:
  - All state and outputs clear.
  - The partial packet already written lacks EOP; recovery is by FIFO reset, which shares the same reset tree.

## Timing
- Reset values:
  - `rq_tx_wr`=0, `rq_tx_wdata`=0, `arb_gnt`=0.
  - `req_rdy`=0, `arb_len_err`=0, `pkt_cnt`=0.
  - FSM in IDLE.
- Cycle budget:
  - Arbitration: 1 cycle from IDLE candidate to BUSY.
  - First beat accepted at the earliest 1 cycle after `req_vld` is seen.
  - Accept to `rq_tx_wr`: 1 cycle.
- Back-to-back packets cost one idle cycle between the EOP beat and the next grant. Peak throughput is (N)/(N+1) beats per cycle for N-beat packets.
- `rq_tx_ff` gates acceptance in the same cycle. The FIFO's 400/512 almost-full level absorbs the one registered beat in flight.
- A requester must hold `req_vld` and `req_data` stable until `req_rdy`.

## Structure
- Shared package `raxi_rq_arb_pkg`:
  - State encoding IDLE=1'b0, BUSY=1'b1.
  - Default `EOP_POS`/`ERR_POS` constants, shared with the RQ FIFO wrapper.
- Sub-module `rr_pick`:
  - Combinational round-robin priority picker: request vector plus last-grant in, one-hot grant out.
  - Reusable for the CQ/CC paths.

## Test plan
- Reset, then port 0 sends a 3-beat packet -> `arb_gnt`=4'b0001 one cycle after `req_vld`; 3 `rq_tx_wr` pulses with data matching bit for bit; `pkt_cnt[0]`=1.
- All 4 ports continuously offer 2-beat packets -> grant order 0,1,2,3,0; each packet contiguous; exactly one idle cycle between packets.
- `rq_tx_ff`=1 for 5 cycles mid-packet on port 2 -> `req_rdy` is 0 for those 5 cycles; no beats lost or duplicated; the packet completes once `rq_tx_ff` drops.
- `reg_arb_en`=4'b1101 with ports 1 and 3 pending -> port 1 is never granted. Clearing `reg_arb_en[3]` during port 3's packet -> that packet still completes.
- Port 1 sends a 40-beat packet with no EOP, `MAX_BEATS`=32 -> beat 32 is written with bits 262 and 261 set; `arb_len_err`=1; FSM returns to IDLE.
- Preload `pkt_cnt[0]` to 16'hFFFF (force), then one packet -> `pkt_cnt[0]`=0. Assert `user_rst` mid-packet -> all outputs 0 the same cycle.
